// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: paces ADC acquisitions and streams each sample as a framed byte sequence
module adc_frame_sequencer #(
  parameter int         DWIDTH   = 8,
  parameter int         CONV_CYC = 16,
  parameter int         TIMEOUT  = 8,
  parameter logic [7:0] HDR      = 8'hA5
) (
  input  logic              clk10m,
  input  logic              rst_n,
  input  logic              en,
  input  logic [15:0]       period,
  output logic              adc_cnv,
  output logic              adc_sclk,
  output logic              ADC_latch,
  input  logic [DWIDTH-1:0] pdo,
  input  logic              pdl,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              clr_err,
  output logic              overrun,
  output logic              pd_timeout,
  output logic              busy
);
  localparam int NB = DWIDTH / 8;

  typedef enum logic [2:0] {IDLE, CONV, SHIFT, LATCH, WAIT_PD, SEND_HDR, SEND_DATA} state_t;

  state_t            state_q, state_d;
  logic [15:0]       per_q, per_d, cnt_q, cnt_d;
  logic [DWIDTH-1:0] sample_q, sample_d;
  logic              tick, ov_set, to_set;

  assign tick  = en && per_q == 16'd0;
  assign per_d = !en ? 16'd0 : tick ? (period == 16'd0 ? 16'd0 : period - 16'd1) : per_q - 16'd1;

  // next-state, phase counter and sample shifter; a tick outside IDLE is only flagged
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    sample_d = sample_q;
    ov_set   = tick && state_q != IDLE;
    to_set   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = 16'd0;
        state_d = tick ? CONV : IDLE;
      end
      CONV: if (cnt_q == 16'(CONV_CYC - 1)) begin
        state_d = SHIFT;
        cnt_d   = 16'd0;
      end
      SHIFT: if (cnt_q == 16'(2 * DWIDTH - 1)) begin
        state_d = LATCH;
        cnt_d   = 16'd0;
      end
      LATCH: begin
        state_d = WAIT_PD;
        cnt_d   = 16'd0;
      end
      WAIT_PD: if (pdl) begin
        sample_d = pdo;
        state_d  = SEND_HDR;
        cnt_d    = 16'd0;
      end else if (cnt_q == 16'(TIMEOUT - 1)) begin
        to_set  = 1'b1;
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
      SEND_HDR: begin
        cnt_d   = 16'd0;
        state_d = tx_ready ? SEND_DATA : SEND_HDR;
      end
      SEND_DATA: begin
        cnt_d = cnt_q;
        if (tx_ready) begin
          sample_d = sample_q << 8;
          state_d  = cnt_q == 16'(NB - 1) ? IDLE : SEND_DATA;
          cnt_d    = cnt_q == 16'(NB - 1) ? 16'd0 : cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // state, counters and outputs registered from next-state values so outputs track state_q
  always_ff @(posedge clk10m) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      per_q      <= 16'd0;
      cnt_q      <= 16'd0;
      sample_q   <= '0;
      adc_cnv    <= 1'b0;
      adc_sclk   <= 1'b0;
      ADC_latch  <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      overrun    <= 1'b0;
      pd_timeout <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      adc_cnv    <= state_d == CONV;
      adc_sclk   <= state_d == SHIFT && cnt_d[0];
      ADC_latch  <= state_d == LATCH;
      tx_valid   <= state_d == SEND_HDR || state_d == SEND_DATA;
      tx_data    <= state_d == SEND_HDR ? HDR : state_d == SEND_DATA ? sample_d[DWIDTH-1 -: 8] : 8'h00;
      overrun    <= ov_set || (overrun && !clr_err);
      pd_timeout <= to_set || (pd_timeout && !clr_err);
      busy       <= state_d != IDLE;
    end
  end
endmodule

// File: doc/adc_frame_sequencer.md
# adc_frame_sequencer

Sequences one ADC sample acquisition per sample period and streams the resulting word out as bytes. It drives the converter's conversion strobe and serial clock, and pulses the latch of the serial-to-parallel capture block. It collects that block's parallel word and emits a framed byte stream (header plus sample bytes) to the UART transmitter over a valid/ready handshake. It sits between the ADC serial front end and the UART, in the 10 MHz domain.

## Interface
- DWIDTH, 8: sample width from the s2p block. Must be 8 or 16.
- CONV_CYC, 16: cycles `adc_cnv` is held high.
- TIMEOUT, 8: max cycles to wait for `pdl` after `ADC_latch`.
- HDR, 8'hA5: frame header byte.

Clock and reset: single clock `clk10m`; reset `rst_n` is synchronous, active-low.

- clk10m  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  sampling enable
- period  in  16  sample period in clk10m cycles; 0 is treated as 1
- adc_cnv  out  1  conversion strobe to ADC
- adc_sclk  out  1  serial clock to ADC
- ADC_latch  out  1  one-cycle latch pulse to s2p
- pdo  in  DWIDTH  parallel word from s2p
- pdl  in  1  one-cycle pdo valid from s2p
- tx_data  out  8  byte to UART
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART accepts byte
- clr_err  in  1  clears sticky flags
- overrun  out  1  sticky: sample tick dropped
- pd_timeout  out  1  sticky: pdl never arrived
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CONV, SHIFT, LATCH, WAIT_PD, SEND_HDR, SEND_DATA.
- Period counter:
  - Runs only while `en`=1; it is held at 0 while `en`=0.
  - A tick occurs when the counter is 0 and `en`=1; the counter then reloads with `period`-1, sampled at the tick.
  - The first tick occurs in the first cycle `en` is sampled high.
- Tick in IDLE: go to CONV.
- Tick in any other state: the tick is dropped, `overrun` is set, and the current frame is unaffected.
- CONV: `adc_cnv`=1 for CONV_CYC cycles, then go to SHIFT.
- SHIFT: 2·DWIDTH cycles.
  - `adc_sclk` is low on the first cycle of each pair and high on the second, giving DWIDTH rising edges.
  - `adc_sclk` is 0 in every other state.
- LATCH: `ADC_latch`=1 for exactly one cycle, then go to WAIT_PD.
- WAIT_PD:
  - On `pdl`=1, register `pdo` into the sample register and go to SEND_HDR.
  - If TIMEOUT cycles pass with no `pdl`, set `pd_timeout` and go to IDLE; no bytes are sent.
  - `pdl` is ignored outside WAIT_PD.
- SEND_HDR: `tx_data`=HDR.
- SEND_DATA: DWIDTH/8 bytes, MSB byte first. After the last accepted byte, go to IDLE.
- Handshake:
  - A byte transfers on a cycle with `tx_valid`=1 and `tx_ready`=1.
  - Once `tx_valid` is asserted, it and `tx_data` stay stable until the transfer.
  - `tx_valid` is 1 only in SEND_HDR and SEND_DATA.
  - The next byte is presented in the cycle after a transfer. There are no bubbles when `tx_ready` stays high.
- `en` falling mid-frame: the frame completes normally, then the block stays IDLE.
- Sticky flags:
  - `clr_err`=1 clears both flags.
  - If a set event and `clr_err` fall on the same cycle, the set wins.
- Reset:
  - All outputs 0, state IDLE, counter 0, sample register 0.
  - Reset asserted mid-frame aborts immediately on that clock edge. This includes dropping `tx_valid` mid-handshake, which is the only permitted case.

## Timing
- All outputs are registered.
- With the tick at cycle 0 (defaults CONV_CYC=16, DWIDTH=8):
  - `adc_cnv` is high in cycles 1–16.
  - `adc_sclk` rises in cycles 18, 20, …, 32.
  - `ADC_latch` is high in cycle 33.
  - WAIT_PD starts in cycle 34.
- `pdl` seen in cycle N: `tx_valid` with HDR in cycle N+1.
- With `tx_ready` held high: HDR is in N+1 and the sample byte in N+2. IDLE is reached in N+3.
- Minimum overrun-free period for the defaults: 34 + pdl delay + 3 cycles.
- A tick arriving in the same cycle the state returns to IDLE is dropped, and `overrun` is set. IDLE is first valid on the following cycle.

## Test plan
- Basic frame:
  - Stimulus: DWIDTH=8, `period`=100, s2p model returns `pdl` 2 cycles after latch with `pdo`=8'h3C, `tx_ready`=1.
  - Required response: `adc_cnv` 16 cycles, 8 `adc_sclk` rises, one latch pulse, bytes A5,3C, next frame exactly 100 cycles after the first.
- Backpressure:
  - Stimulus: DWIDTH=16, `pdo`=16'hBEEF, `tx_ready` low for 5 cycles per byte.
  - Required response: bytes A5,BE,EF in order; `tx_data` stable throughout each stall.
- Overrun:
  - Stimulus: `period`=20.
  - Required response: every second tick is dropped, `overrun`=1 after the first drop, frames stay intact. A `clr_err` pulse clears the flag until the next drop.
- Timeout:
  - Stimulus: s2p model never asserts `pdl`.
  - Required response: `pd_timeout`=1 exactly 8 cycles after WAIT_PD entry, no `tx_valid`, next tick starts a fresh CONV.
- Enable and reset:
  - Stimulus: drop `en` during SHIFT.
  - Required response: the frame completes and no further `adc_cnv`.
  - Stimulus: assert `rst_n`=0 during SEND_DATA.
  - Required response: on the next edge all outputs are 0 and `busy`=0.
- Simultaneous events:
  - Stimulus: a tick coincides with `clr_err` while busy.
  - Required response: `overrun` ends at 1.
